// File: rtl/crg_job_arbiter.sv
// crg_job_arbiter: shares one CRG triple generator between N_REQ requesters.
// Round-robin accepts job descriptors and programs the CRG counter range.
// It pulses run, counts dvld beats and reports done or error per job.
module crg_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [3*N_REQ-1:0]    req_width_i,
  input  logic [3*N_REQ-1:0]    req_mode_i,
  input  logic [32*N_REQ-1:0]   req_cnt_start_i,
  input  logic [32*N_REQ-1:0]   req_n_i,
  output logic [2:0]            crg_width_o,
  output logic [2:0]            crg_mode_o,
  output logic [31:0]           crg_cnt_start_o,
  output logic [31:0]           crg_cnt_end_o,
  output logic                  crg_run_o,
  input  logic                  crg_dvld_i,
  output logic                  out_vld_o,
  output logic [ID_W-1:0]       owner_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ID_W-1:0]       done_id_o
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_INIT = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Round-robin pointer, job owner and job progress
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] owner_q;
  logic            err_q;
  logic [31:0]     beat_q;
  logic [WD_W-1:0] wd_q;

  // Descriptor captured at accept time
  logic [2:0]  lat_width;
  logic [2:0]  lat_mode;
  logic [31:0] lat_start;
  logic [31:0] lat_n;

  // CRG configuration registers
  logic [2:0]  cfg_width_q;
  logic [2:0]  cfg_mode_q;
  logic [31:0] cfg_start_q;
  logic [31:0] cfg_end_q;

  // Arbitration results
  logic            found;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] next_rr;
  logic [2:0]      sel_width;
  logic [2:0]      sel_mode;
  logic [31:0]     sel_start;
  logic [31:0]     sel_n;

  // Range check results
  logic [32:0] end_ext;
  logic        arm_bad;

  // Last counter value of a job, carried in 33 bits so a wrap past
  // 32'hFFFF_FFFF shows up in bit 32.
  function automatic logic [32:0] range_end(input logic [31:0] start,
                                            input logic [31:0] n);
    return {1'b0, start} + {1'b0, n} - 33'd1;
  endfunction

  // An empty job or one whose range wraps cannot be handed to the CRG.
  function automatic logic range_bad(input logic [31:0] n,
                                     input logic [32:0] last);
    return (n == 32'd0) || last[32];
  endfunction

  assign end_ext = range_end(lat_start, lat_n);
  assign arm_bad = range_bad(lat_n, end_ext);

  // Cyclic search: first pass covers rr_q..N_REQ-1, second pass wraps to 0
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_valid_i[j] && (ID_W'(j) >= rr_q)) begin
        found = 1'b1;
        grant = ID_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_valid_i[j]) begin
        found = 1'b1;
        grant = ID_W'(j);
      end
    end
  end

  assign next_rr = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

  // Select the granted requester's descriptor slice
  always_comb begin
    sel_width = '0;
    sel_mode  = '0;
    sel_start = '0;
    sel_n     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant == ID_W'(j)) begin
        sel_width = req_width_i[3*j +: 3];
        sel_mode  = req_mode_i[3*j +: 3];
        sel_start = req_cnt_start_i[32*j +: 32];
        sel_n     = req_n_i[32*j +: 32];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and per-state strobes
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    crg_run_o   = 1'b0;
    out_vld_o   = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    done_id_o   = '0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (found) begin
          req_ready_o = N_REQ'(1) << grant;
          state_d     = S_ARM;
        end
      end
      S_ARM: begin
        state_d = arm_bad ? S_DONE : S_RUN;
      end
      S_RUN: begin
        crg_run_o = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        out_vld_o = crg_dvld_i;
        if (crg_dvld_i) begin
          if (beat_q == 32'd1) begin
            state_d = S_DONE;
          end
        end else if (wd_q == WD_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o    = 1'b1;
        err_o     = err_q;
        done_id_o = owner_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Job control: pointer, owner, error flag, beat counter and watchdog
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            owner_q <= grant;
            rr_q    <= next_rr;
          end
        end
        S_ARM: begin
          if (arm_bad) begin
            err_q <= 1'b1;
          end
        end
        S_RUN: begin
          beat_q <= lat_n;
          wd_q   <= WD_INIT;
        end
        S_WAIT: begin
          if (crg_dvld_i) begin
            beat_q <= beat_q - 32'd1;
            wd_q   <= WD_INIT;
          end else begin
            wd_q <= wd_q - WD_W'(1);
            if (wd_q == WD_W'(1)) begin
              err_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Descriptor capture on accept; pure data, no reset needed
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && found) begin
      lat_width <= sel_width;
      lat_mode  <= sel_mode;
      lat_start <= sel_start;
      lat_n     <= sel_n;
    end
  end

  // CRG configuration: loaded only for a runnable job, held until next ARM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_width_q <= '0;
      cfg_mode_q  <= '0;
      cfg_start_q <= '0;
      cfg_end_q   <= '0;
    end else if (state_q == S_ARM && !arm_bad) begin
      cfg_width_q <= lat_width;
      cfg_mode_q  <= lat_mode;
      cfg_start_q <= lat_start;
      cfg_end_q   <= end_ext[31:0];
    end
  end

  assign crg_width_o     = cfg_width_q;
  assign crg_mode_o      = cfg_mode_q;
  assign crg_cnt_start_o = cfg_start_q;
  assign crg_cnt_end_o   = cfg_end_q;
  assign owner_o         = owner_q;

endmodule

// File: tb/tb_crg_job_arbiter.sv
// Bench for crg_job_arbiter: directed scenarios plus randomized request mixes,
// checked against a job-level reference model.
module tb_crg_job_arbiter;

  localparam int NR      = 4;
  localparam int TIMEOUT = 16;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready_o;
  logic [11:0]  req_width;
  logic [11:0]  req_mode;
  logic [127:0] req_start;
  logic [127:0] req_n;
  logic [2:0]   crg_width_o;
  logic [2:0]   crg_mode_o;
  logic [31:0]  crg_cnt_start_o;
  logic [31:0]  crg_cnt_end_o;
  logic         crg_run_o;
  logic         crg_dvld_i;
  logic         out_vld_o;
  logic [1:0]   owner_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [1:0]   done_id_o;

  logic [2:0]  d_w     [NR];
  logic [2:0]  d_m     [NR];
  logic [31:0] d_start [NR];
  logic [31:0] d_n     [NR];

  int          n_checks;
  int          n_fail;
  logic [1:0]  rr_model;
  logic [31:0] last_end;
  logic [1:0]  g;

  crg_job_arbiter #(.N_REQ(NR), .ID_W(2), .TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .req_width_i     (req_width),
    .req_mode_i      (req_mode),
    .req_cnt_start_i (req_start),
    .req_n_i         (req_n),
    .crg_width_o     (crg_width_o),
    .crg_mode_o      (crg_mode_o),
    .crg_cnt_start_o (crg_cnt_start_o),
    .crg_cnt_end_o   (crg_cnt_end_o),
    .crg_run_o       (crg_run_o),
    .crg_dvld_i      (crg_dvld_i),
    .out_vld_o       (out_vld_o),
    .owner_o         (owner_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .done_id_o       (done_id_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    req_width = '0;
    req_mode  = '0;
    req_start = '0;
    req_n     = '0;
    for (int r = 0; r < NR; r++) begin
      req_width[3*r +: 3]  = d_w[r];
      req_mode[3*r +: 3]   = d_m[r];
      req_start[32*r +: 32] = d_start[r];
      req_n[32*r +: 32]     = d_n[r];
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  // Reference arbitration: first valid requester at or after the pointer.
  function automatic logic [1:0] model_grant(input logic [3:0] v, input logic [1:0] rr);
    logic [1:0] idx;
    for (int k = 0; k < NR; k++) begin
      idx = rr + 2'(k);
      if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
    end
    return rr;
  endfunction

  task automatic set_desc(input logic [1:0] r, input logic [31:0] st, input logic [31:0] n,
                          input logic [2:0] w, input logic [2:0] m);
    d_start[r] = st;
    d_n[r]     = n;
    d_w[r]     = w;
    d_m[r]     = m;
  endtask

  task automatic rand_desc(input logic [1:0] r);
    logic [31:0] st;
    if ($urandom_range(3, 0) == 0) st = 32'hFFFF_FFF8 + 32'($urandom_range(7, 0));
    else st = $urandom;
    set_desc(r, st, 32'($urandom_range(6, 0)), 3'($urandom), 3'($urandom));
  endtask

  // Follow one job for requester gq from accept to done, driving dvld beats.
  // stall_after >= 0 stops the CRG after that many beats and expects a timeout.
  task automatic serve(input logic [1:0] gq, input int gap_lo, input int gap_hi,
                       input int stall_after);
    logic [31:0] st, nn, exp_end;
    logic [63:0] sum64;
    logic        exp_err;
    int          k;
    bit          stalled;
    st      = d_start[gq];
    nn      = d_n[gq];
    sum64   = {32'd0, st} + {32'd0, nn};
    exp_err = (nn == 32'd0) || (sum64 > 64'h1_0000_0000);
    exp_end = sum64[31:0] - 32'd1;
    #2;
    k = 0;
    while (req_ready_o === 4'b0000 && k < 40) begin
      adv();
      #2;
      k++;
    end
    check("grant", 64'(req_ready_o), 64'(4'b0001 << gq));
    check("idle_busy", 64'(busy_o), 64'(0));
    check("idle_done", 64'(done_o), 64'(0));
    adv();
    req_valid  = req_valid & ~(4'b0001 << gq);
    crg_dvld_i = 1'($urandom_range(1, 0));
    #2;
    check("arm_busy", 64'(busy_o), 64'(1));
    check("arm_owner", 64'(owner_o), 64'(gq));
    check("arm_ready", 64'(req_ready_o), 64'(0));
    check("arm_outvld", 64'(out_vld_o), 64'(0));
    check("arm_run", 64'(crg_run_o), 64'(0));
    if (exp_err) begin
      adv();
      crg_dvld_i = 1'b1;
      #2;
      check("err_run", 64'(crg_run_o), 64'(0));
      check("err_outvld", 64'(out_vld_o), 64'(0));
      check("err_done", 64'(done_o), 64'(1));
      check("err_err", 64'(err_o), 64'(1));
      check("err_done_id", 64'(done_id_o), 64'(gq));
      check("err_cfg_kept", 64'(crg_cnt_end_o), 64'(last_end));
    end else begin
      adv();
      crg_dvld_i = 1'($urandom_range(1, 0));
      #2;
      check("run_pulse", 64'(crg_run_o), 64'(1));
      check("run_outvld", 64'(out_vld_o), 64'(0));
      check("cfg_start", 64'(crg_cnt_start_o), 64'(st));
      check("cfg_end", 64'(crg_cnt_end_o), 64'(exp_end));
      check("cfg_width", 64'(crg_width_o), 64'(d_w[gq]));
      check("cfg_mode", 64'(crg_mode_o), 64'(d_m[gq]));
      last_end = exp_end;
      stalled  = 1'b0;
      for (int b = 0; b < int'(nn) && !stalled; b++) begin
        if (b == stall_after) begin
          // done_o is expected TIMEOUT+1 cycles after the cycle holding the last beat
          k = 0;
          do begin
            adv();
            crg_dvld_i = 1'b0;
            #2;
            k++;
          end while (done_o !== 1'b1 && k < 40);
          check("timeout_cycles", 64'(k), 64'(TIMEOUT + 1));
          check("timeout_err", 64'(err_o), 64'(1));
          check("timeout_done_id", 64'(done_id_o), 64'(gq));
          stalled = 1'b1;
        end else begin
          repeat ($urandom_range(gap_hi, gap_lo)) begin
            adv();
            crg_dvld_i = 1'b0;
            #2;
            check("gap_outvld", 64'(out_vld_o), 64'(0));
            check("gap_done", 64'(done_o), 64'(0));
          end
          adv();
          crg_dvld_i = 1'b1;
          #2;
          check("beat_vld", 64'(out_vld_o), 64'(1));
          check("beat_owner", 64'(owner_o), 64'(gq));
          check("beat_done", 64'(done_o), 64'(0));
        end
      end
      if (!stalled) begin
        adv();
        crg_dvld_i = 1'($urandom_range(1, 0));
        #2;
        check("done_pulse", 64'(done_o), 64'(1));
        check("done_err", 64'(err_o), 64'(0));
        check("done_id", 64'(done_id_o), 64'(gq));
        check("done_outvld", 64'(out_vld_o), 64'(0));
      end
    end
    rr_model = gq + 2'd1;
    adv();
    crg_dvld_i = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rr_model   = 2'd0;
    last_end   = 32'd0;
    rst_i      = 1'b1;
    req_valid  = 4'b0000;
    crg_dvld_i = 1'b0;
    for (int r = 0; r < NR; r++) set_desc(2'(r), 32'd0, 32'd0, 3'd0, 3'd0);

    // Reset state
    repeat (3) @(posedge clk_i);
    #3;
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    check("rst_run", 64'(crg_run_o), 64'(0));
    check("rst_owner", 64'(owner_o), 64'(0));
    check("rst_done_id", 64'(done_id_o), 64'(0));
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_cfg", 64'({crg_width_o, crg_mode_o, crg_cnt_start_o, crg_cnt_end_o}), 64'(0));
    adv();
    rst_i = 1'b0;

    // Single job: start 3, n 5 -> end 7
    set_desc(2'd0, 32'd3, 32'd5, 3'b111, 3'b010);
    req_valid = 4'b0001;
    serve(2'd0, 0, 0, -1);

    // n = 0 from requester 3: error, pointer returns to 0
    set_desc(2'd3, 32'd40, 32'd0, 3'b001, 3'b001);
    req_valid = 4'b1000;
    serve(2'd3, 0, 0, -1);

    // Round-robin: all valid twice, grants follow the model order
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < NR; r++) set_desc(2'(r), 32'(100 * r + 10), 32'd2, 3'(r), 3'(r + 1));
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) begin
        g = model_grant(req_valid, rr_model);
        serve(g, 0, 2, -1);
      end
    end

    // Wrap: n = 3 past the top is rejected, n = 2 ends exactly at the top
    set_desc(2'd0, 32'hFFFF_FFFE, 32'd3, 3'b010, 3'b011);
    req_valid = 4'b0001;
    serve(2'd0, 0, 0, -1);
    set_desc(2'd1, 32'hFFFF_FFFE, 32'd2, 3'b100, 3'b101);
    req_valid = 4'b0010;
    serve(2'd1, 0, 1, -1);

    // Timeout after 1 of 4 beats, then a job whose beats land on the expiry cycle
    set_desc(2'd2, 32'd500, 32'd4, 3'b011, 3'b000);
    req_valid = 4'b0100;
    serve(2'd2, 0, 0, 1);
    set_desc(2'd3, 32'd900, 32'd3, 3'b110, 3'b111);
    req_valid = 4'b1000;
    serve(2'd3, TIMEOUT - 1, TIMEOUT - 1, -1);

    // Randomized request mixes; held requests must eventually be served
    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < NR; r++) begin
        if (((req_valid >> r) & 4'b0001) == 4'b0000 && $urandom_range(1, 0) == 1) begin
          rand_desc(2'(r));
          req_valid = req_valid | (4'b0001 << r);
        end
      end
      if (req_valid == 4'b0000) begin
        g = 2'($urandom_range(3, 0));
        rand_desc(g);
        req_valid = 4'b0001 << g;
      end
      g = model_grant(req_valid, rr_model);
      serve(g, 0, 3, -1);
    end
    while (req_valid != 4'b0000) begin
      g = model_grant(req_valid, rr_model);
      serve(g, 0, 3, -1);
    end

    // Reset in WAIT after 2 of 10 beats
    set_desc(2'd1, 32'd1000, 32'd10, 3'b101, 3'b110);
    req_valid = 4'b0010;
    #2;
    check("mid_grant", 64'(req_ready_o), 64'(4'b0010));
    adv();
    req_valid = 4'b0000;
    adv();
    adv();
    crg_dvld_i = 1'b1;
    adv();
    crg_dvld_i = 1'b1;
    adv();
    crg_dvld_i = 1'b1;
    #1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'(0));
    check("mid_rst_outvld", 64'(out_vld_o), 64'(0));
    check("mid_rst_owner", 64'(owner_o), 64'(0));
    check("mid_rst_done", 64'(done_o), 64'(0));
    check("mid_rst_cfg_end", 64'(crg_cnt_end_o), 64'(0));
    adv();
    #2;
    check("mid_rst_no_done", 64'(done_o), 64'(0));
    check("mid_rst_run", 64'(crg_run_o), 64'(0));
    adv();
    rst_i      = 1'b0;
    crg_dvld_i = 1'b0;
    rr_model   = 2'd0;
    last_end   = 32'd0;
    set_desc(2'd0, 32'd7, 32'd3, 3'b001, 3'b010);
    set_desc(2'd2, 32'd77, 32'd2, 3'b011, 3'b100);
    req_valid = 4'b0101;
    g = model_grant(req_valid, rr_model);
    serve(g, 0, 2, -1);
    g = model_grant(req_valid, rr_model);
    serve(g, 0, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
